// File: rtl/com_bus_arbiter_4core_if.sv
// Common-bus request/grant bundle between the four cache wrappers (master) and the arbiter (slave).
// Arb_timeout is present only when COM_BUS_TIMEOUT_EN is defined.
interface com_bus_arbiter_4core_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0] Com_Bus_Req_proc;
    logic [NUM_CORES-1:0] Com_Bus_Req_snoop;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_proc;
    logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop;
    logic                 Bus_busy;
    logic [1:0]           Proc_owner;
`ifdef COM_BUS_TIMEOUT_EN
    logic                 Arb_timeout;
`endif

    modport master (
        output Com_Bus_Req_proc,
        output Com_Bus_Req_snoop,
        input  Com_Bus_Gnt_proc,
        input  Com_Bus_Gnt_snoop,
        input  Bus_busy,
        input  Proc_owner
`ifdef COM_BUS_TIMEOUT_EN
        ,
        input  Arb_timeout
`endif
    );

    modport slave (
        input  Com_Bus_Req_proc,
        input  Com_Bus_Req_snoop,
        output Com_Bus_Gnt_proc,
        output Com_Bus_Gnt_snoop,
        output Bus_busy,
        output Proc_owner
`ifdef COM_BUS_TIMEOUT_EN
        ,
        output Arb_timeout
`endif
    );
endinterface

// File: rtl/com_bus_arbiter_4core.sv
// Common-bus arbiter for 4 cores: round-robin processor tenures with nested fixed-priority snoops, 1-cycle grant latency.
// Grants are held while the request stays high; COM_BUS_TIMEOUT_EN adds a bounded processor tenure with Arb_timeout.
module com_bus_arbiter_4core #(
    parameter int NUM_CORES = 4
`ifdef COM_BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    com_bus_arbiter_4core_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PROC,
        S_PROC_SNOOP,
        S_SNOOP,
        S_TURN
    } state_t;

    state_t               r_state;
    logic [NUM_CORES-1:0] r_gnt_proc;
    logic [NUM_CORES-1:0] r_gnt_snoop;
    logic                 r_busy;
    logic [1:0]           r_owner;
    logic [1:0]           r_ptr;
    logic [1:0]           r_snoop_idx;

    logic [NUM_CORES-1:0] w_snoop_ex;
    logic [1:0]           w_snoop_idx;
    logic [1:0]           w_snoop_ex_idx;
    logic [1:0]           w_proc_idx;
    logic                 w_issue_proc;
    logic                 w_proc_own;
    logic                 w_snoop_own;
    logic                 w_tmo;

    function automatic logic [1:0] f_first(input logic [NUM_CORES-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_CORES-1:0] f_oh(input logic [1:0] idx);
        return NUM_CORES'(1) << idx;
    endfunction

    // The current processor owner's own snoop request is masked out while it holds the bus.
    always_comb begin
        w_snoop_ex     = bus.Com_Bus_Req_snoop & ~r_gnt_proc;
        w_snoop_idx    = f_first(bus.Com_Bus_Req_snoop);
        w_snoop_ex_idx = f_first(w_snoop_ex);
        w_proc_idx     = r_ptr;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bus.Com_Bus_Req_proc[r_ptr + 2'(i)]) w_proc_idx = r_ptr + 2'(i);
        end
        w_issue_proc = (r_state == S_IDLE) && !(|bus.Com_Bus_Req_snoop) && (|bus.Com_Bus_Req_proc);
        w_proc_own   = bus.Com_Bus_Req_proc[r_owner];
        w_snoop_own  = bus.Com_Bus_Req_snoop[r_snoop_idx];
    end

`ifdef COM_BUS_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_issue_proc)
                r_cnt <= '0;
            else if (r_state == S_PROC || r_state == S_PROC_SNOOP)
                r_cnt <= r_cnt + CNT_W'(1);
            r_timeout <= (r_state == S_PROC || r_state == S_PROC_SNOOP) && w_proc_own && w_tmo;
        end
    end

    assign bus.Arb_timeout = r_timeout;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt_proc  <= '0;
            r_gnt_snoop <= '0;
            r_busy      <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_snoop_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|bus.Com_Bus_Req_snoop) begin
                        r_gnt_snoop <= f_oh(w_snoop_idx);
                        r_snoop_idx <= w_snoop_idx;
                        r_busy      <= 1'b1;
                        r_state     <= S_SNOOP;
                    end else if (w_issue_proc) begin
                        r_gnt_proc <= f_oh(w_proc_idx);
                        r_owner    <= w_proc_idx;
                        r_busy     <= 1'b1;
                        r_state    <= S_PROC;
                    end
                end
                S_PROC: begin
                    if (!w_proc_own || w_tmo) begin
                        r_gnt_proc <= '0;
                        r_busy     <= 1'b0;
                        r_ptr      <= r_owner + 2'd1;
                        r_state    <= S_TURN;
                    end else if (|w_snoop_ex) begin
                        r_gnt_snoop <= f_oh(w_snoop_ex_idx);
                        r_snoop_idx <= w_snoop_ex_idx;
                        r_state     <= S_PROC_SNOOP;
                    end
                end
                S_PROC_SNOOP: begin
                    // A processor drop wins over a forced release; the snoop may outlive the tenure.
                    if (!w_proc_own) begin
                        r_gnt_proc <= '0;
                        r_ptr      <= r_owner + 2'd1;
                        if (w_snoop_own) begin
                            r_state <= S_SNOOP;
                        end else begin
                            r_gnt_snoop <= '0;
                            r_busy      <= 1'b0;
                            r_state     <= S_TURN;
                        end
                    end else if (w_tmo) begin
                        r_gnt_proc  <= '0;
                        r_gnt_snoop <= '0;
                        r_busy      <= 1'b0;
                        r_ptr       <= r_owner + 2'd1;
                        r_state     <= S_TURN;
                    end else if (!w_snoop_own) begin
                        r_gnt_snoop <= '0;
                        r_state     <= S_PROC;
                    end
                end
                S_SNOOP: begin
                    if (!w_snoop_own) begin
                        r_gnt_snoop <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= S_TURN;
                    end
                end
                S_TURN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt_proc  <= '0;
                    r_gnt_snoop <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Com_Bus_Gnt_proc  = r_gnt_proc;
    assign bus.Com_Bus_Gnt_snoop = r_gnt_snoop;
    assign bus.Bus_busy          = r_busy;
    assign bus.Proc_owner        = r_owner;
endmodule

// File: tb/tb_com_bus_arbiter_4core.sv
// Bench for the common-bus arbiter: directed scenarios plus random requests against a holder-based reference model.
module tb_com_bus_arbiter_4core;
`ifdef COM_BUS_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    com_bus_arbiter_4core_if #(.NUM_CORES(4)) bus_if ();

`ifdef COM_BUS_TIMEOUT_EN
    com_bus_arbiter_4core #(.NUM_CORES(4), .TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );
`else
    com_bus_arbiter_4core #(.NUM_CORES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );
`endif

    // Reference model: who holds the bus, and how many idle cycles must pass before arbitrating again.
    int m_po    = -1;
    int m_so    = -1;
    int m_ptr   = 0;
    int m_owner = 0;
    int m_quiet = 0;
    int m_ten   = 0;
    bit m_tmo   = 1'b0;

    function automatic int lowest(input logic [3:0] v, input int skip);
        for (int i = 0; i < 4; i++) begin
            if (v[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] rp, input logic [3:0] rs, input logic r);
        bit had;
        m_tmo = 1'b0;
        if (r) begin
            m_po = -1; m_so = -1; m_ptr = 0; m_owner = 0; m_quiet = 0; m_ten = 0;
            return;
        end
        had = (m_po >= 0) || (m_so >= 0);
        if (m_po >= 0) begin
            if (!rp[m_po]) begin
                m_ptr = (m_po + 1) % 4;
                m_po  = -1;
                if (m_so >= 0 && !rs[m_so]) m_so = -1;
            end else begin
                m_ten++;
                if (TMO > 0 && m_ten == TMO) begin
                    m_ptr = (m_po + 1) % 4;
                    m_po  = -1;
                    m_so  = -1;
                    m_tmo = 1'b1;
                end else if (m_so >= 0) begin
                    if (!rs[m_so]) m_so = -1;
                end else begin
                    m_so = lowest(rs, m_po);
                end
            end
        end else if (m_so >= 0) begin
            if (!rs[m_so]) m_so = -1;
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (rs != 4'b0) begin
            m_so = lowest(rs, -1);
        end else if (rp != 4'b0) begin
            for (int k = 3; k >= 0; k--) begin
                if (rp[(m_ptr + k) % 4]) m_po = (m_ptr + k) % 4;
            end
            m_owner = m_po;
            m_ten   = 0;
        end
        if (had && m_po < 0 && m_so < 0) m_quiet = 1;
    endtask

    task automatic compare_all();
        logic [3:0] exp_gp;
        logic [3:0] exp_gs;
        exp_gp = (m_po >= 0) ? 4'(1 << m_po) : 4'b0;
        exp_gs = (m_so >= 0) ? 4'(1 << m_so) : 4'b0;
        chk_eq("gnt_proc", bus_if.Com_Bus_Gnt_proc, exp_gp);
        chk_eq("gnt_snoop", bus_if.Com_Bus_Gnt_snoop, exp_gs);
        chk_eq("bus_busy", bus_if.Bus_busy, (exp_gp | exp_gs) != 4'b0);
        chk_eq("proc_owner", bus_if.Proc_owner, m_owner);
`ifdef COM_BUS_TIMEOUT_EN
        chk_eq("arb_timeout", bus_if.Arb_timeout, m_tmo);
`endif
        chk_eq("onehot_proc", $countones(bus_if.Com_Bus_Gnt_proc) <= 1, 1);
        chk_eq("onehot_snoop", $countones(bus_if.Com_Bus_Gnt_snoop) <= 1, 1);
        chk_eq("no_overlap", |(bus_if.Com_Bus_Gnt_proc & bus_if.Com_Bus_Gnt_snoop), 0);
    endtask

    // Drive inputs before the edge, advance the model on the edge, compare on the falling edge.
    task automatic tick(input logic [3:0] rp, input logic [3:0] rs, input logic r);
        bus_if.Com_Bus_Req_proc  = rp;
        bus_if.Com_Bus_Req_snoop = rs;
        rst = r;
        @(posedge clk);
        model_edge(rp, rs, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [3:0] rp;
        logic [3:0] rs;
        logic [3:0] gp;
        logic [3:0] prev;
        int         held;
        int         nev;
        int         gap;
        int         min_gap;
        int         order[5];
        int         run3;
        int         ntmo;
        bit         left3;
        bit         got;
        logic [3:0] nxt;

        bus_if.Com_Bus_Req_proc  = 4'b0;
        bus_if.Com_Bus_Req_snoop = 4'b0;
        rst = 1'b1;

        // Reset values, then a single processor tenure from core 2.
        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b0000, 4'b0000, 1'b1);
        chk_eq("rst_gnt_proc", bus_if.Com_Bus_Gnt_proc, 4'b0);
        chk_eq("rst_busy", bus_if.Bus_busy, 1'b0);
        chk_eq("rst_owner", bus_if.Proc_owner, 2'd0);
        tick(4'b0100, 4'b0000, 1'b0);
        chk_eq("t1_grant", bus_if.Com_Bus_Gnt_proc, 4'b0100);
        repeat (4) tick(4'b0100, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        chk_eq("t1_drop", bus_if.Com_Bus_Gnt_proc, 4'b0000);
        chk_eq("t1_owner", bus_if.Proc_owner, 2'd2);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b1001, 4'b0000, 1'b0);
        chk_eq("t1_ptr3", bus_if.Com_Bus_Gnt_proc, 4'b1000);
        repeat (3) tick(4'b0000, 4'b0000, 1'b0);

        // All four cores requesting; each releases after two granted cycles.
        tick(4'b0000, 4'b0000, 1'b1);
        rp = 4'hF; held = 0; nev = 0; prev = 4'b0; gap = 0; min_gap = 99;
        for (int c = 0; c < 60 && nev < 5; c++) begin
            tick(rp, 4'b0000, 1'b0);
            gp = bus_if.Com_Bus_Gnt_proc;
            rp = 4'hF;
            if (gp != 4'b0) begin
                if (prev == 4'b0) begin
                    order[nev] = lowest(gp, -1);
                    if (nev > 0 && gap < min_gap) min_gap = gap;
                    nev++;
                    held = 1;
                end else begin
                    held++;
                end
                if (held == 2) rp = ~gp;
                gap = 0;
            end else begin
                gap++;
            end
            prev = gp;
        end
        chk_eq("rr_events", nev, 5);
        for (int i = 0; i < 5; i++) chk_eq("rr_order", order[i], i % 4);
        chk_eq("rr_turn_gap", min_gap >= 1, 1);

        // Snoop nested in core 1's tenure; owner's own snoop bit is ignored.
        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b0010, 4'b0000, 1'b0);
        tick(4'b0010, 4'b1010, 1'b0);
        chk_eq("t3_snoop", bus_if.Com_Bus_Gnt_snoop, 4'b1000);
        chk_eq("t3_proc_kept", bus_if.Com_Bus_Gnt_proc, 4'b0010);
        tick(4'b0010, 4'b1010, 1'b0);
        tick(4'b0010, 4'b0010, 1'b0);
        chk_eq("t3_snoop_drop", bus_if.Com_Bus_Gnt_snoop, 4'b0000);
        chk_eq("t3_proc_still", bus_if.Com_Bus_Gnt_proc, 4'b0010);
        tick(4'b0000, 4'b0010, 1'b0);
        repeat (4) tick(4'b0000, 4'b0000, 1'b0);

        // Simultaneous snoop and processor arrival: snoop first.
        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b0001, 4'b0100, 1'b0);
        chk_eq("t4_snoop_first", bus_if.Com_Bus_Gnt_snoop, 4'b0100);
        chk_eq("t4_no_proc", bus_if.Com_Bus_Gnt_proc, 4'b0000);
        tick(4'b0001, 4'b0000, 1'b0);
        tick(4'b0001, 4'b0000, 1'b0);
        tick(4'b0001, 4'b0000, 1'b0);
        chk_eq("t4_proc_after", bus_if.Com_Bus_Gnt_proc, 4'b0001);
        repeat (3) tick(4'b0000, 4'b0000, 1'b0);

        // Reset while in PROC_SNOOP with the pointer advanced to 3.
        tick(4'b0000, 4'b0000, 1'b1);
        tick(4'b0100, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0000, 1'b0);
        tick(4'b0010, 4'b0001, 1'b0);
        chk_eq("t5_nested", bus_if.Com_Bus_Gnt_snoop, 4'b0001);
        tick(4'b0010, 4'b0001, 1'b1);
        chk_eq("t5_rst_proc", bus_if.Com_Bus_Gnt_proc, 4'b0000);
        chk_eq("t5_rst_snoop", bus_if.Com_Bus_Gnt_snoop, 4'b0000);
        chk_eq("t5_rst_busy", bus_if.Bus_busy, 1'b0);
        tick(4'b1111, 4'b0000, 1'b0);
        chk_eq("t5_ptr0", bus_if.Com_Bus_Gnt_proc, 4'b0001);
        tick(4'b0000, 4'b0000, 1'b1);

`ifdef COM_BUS_TIMEOUT_EN
        // Core 3 overstays its tenure while core 0 waits.
        tick(4'b1000, 4'b0000, 1'b0);
        run3 = (bus_if.Com_Bus_Gnt_proc == 4'b1000) ? 1 : 0;
        ntmo = 0; left3 = 1'b0; got = 1'b0; nxt = 4'b0;
        for (int c = 1; c < 20; c++) begin
            tick(4'b1001, 4'b0000, 1'b0);
            gp = bus_if.Com_Bus_Gnt_proc;
            if (gp == 4'b1000 && !left3) run3++;
            else left3 = 1'b1;
            if (!got && gp != 4'b0 && gp != 4'b1000) begin
                nxt = gp;
                got = 1'b1;
            end
            if (c <= 12 && bus_if.Arb_timeout) ntmo++;
        end
        chk_eq("t6_tenure_len", run3, 8);
        chk_eq("t6_pulses", ntmo, 1);
        chk_eq("t6_next_grant", nxt, 4'b0001);
        tick(4'b0000, 4'b0000, 1'b1);
`else
        run3 = 0; ntmo = 0; left3 = 1'b0; got = 1'b0; nxt = 4'b0;
`endif

        // Random request traffic with occasional resets.
        rp = 4'b0; rs = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) rp[i] = ~rp[i];
                if ($urandom_range(0, 9) == 0) rs[i] = ~rs[i];
            end
            tick(rp, rs, ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/com_bus_arbiter_4core.md
Name: com_bus_arbiter_4core

Overview:
- Arbitrates the shared common bus (Address_Com, Data_Bus_Com, BusRd, BusRdX, Invalidate, Data_in_Bus) among the four cache wrappers of the multi-core system.
- Each core presents a processor-side request (miss or upgrade) and a snoop-side request (flush or supply data).
- Processor requests are served round-robin. Snoop requests are nested inside, or served alongside, processor tenures with fixed priority.
- Sits at top level between the cache wrappers and the bus/memory model.

Parameters:
- NUM_CORES, 4, number of requesting cores. Fixed at 4 for this revision; the owner encoding is 2 bits.
- TIMEOUT_CYCLES, 256, maximum processor tenure length. Used only when the optional feature is enabled.
- CNT_W, 9, width of the tenure counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- Com_Bus_Req_proc  in  4  per-core processor bus request; bit i = core i
- Com_Bus_Req_snoop  in  4  per-core snoop bus request
- Com_Bus_Gnt_proc  out  4  one-hot-or-zero processor grant
- Com_Bus_Gnt_snoop  out  4  one-hot-or-zero snoop grant
- Bus_busy  out  1  high while any grant is asserted
- Proc_owner  out  2  index of current or last processor grantee
- Arb_timeout  out  1  one-cycle pulse on forced release (present only with COM_BUS_TIMEOUT_EN)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - Gnt_proc = 0, Gnt_snoop = 0, Bus_busy = 0, Proc_owner = 0, Arb_timeout = 0.
  - Round-robin pointer = 0, tenure counter = 0, state = IDLE.
- Reset mid-tenure: all grants drop on the reset edge, with no completion handshake.
- All outputs are registered. A request sampled at edge N gives a grant visible after edge N, i.e. 1-cycle latency.
- State machine:
  - IDLE: no grant held.
    - If any snoop request is pending, grant the lowest-index snoop requester → SNOOP.
    - Else if any processor request is pending, grant the first requester at or after the pointer, wrapping 3→0 → PROC.
    - Snoop wins any simultaneous arrival.
  - PROC: Gnt_proc[k] is held while Req_proc[k] stays high.
    - If Req_snoop[j] is high with j≠k, assert Gnt_snoop[j] alongside → PROC_SNOOP. Lowest j wins.
    - Req_snoop[k] is ignored while core k holds the processor grant.
    - When Req_proc[k] drops: Gnt_proc drops, pointer = k+1 mod 4 → TURN.
  - PROC_SNOOP: both grants held.
    - When Req_snoop[j] drops, Gnt_snoop drops → PROC.
    - If Req_proc[k] drops first, Gnt_proc drops and the snoop grant is retained → SNOOP. Pointer updates as in PROC.
    - If both drop in the same cycle, both grants drop → TURN.
  - SNOOP: Gnt_snoop[j] held until Req_snoop[j] drops → TURN. No new processor grant is issued while in SNOOP.
  - TURN: one cycle with all grants low (bus turnaround), then → IDLE.
- Minimum gap: at least one grant-free cycle between consecutive processor tenures. Back-to-back arbitration gives a grant every 3rd cycle at best.
- Proc_owner updates when a processor grant is issued and holds its value after release.
- Bus_busy = |Gnt_proc | |Gnt_snoop.
- Invariants, which must hold in every cycle:
  - At most one Gnt_proc bit set.
  - At most one Gnt_snoop bit set.
  - Gnt_proc[i] and Gnt_snoop[i] never both set.
- A request deasserted before its grant arrives is not recorded. If the grant was already issued, it is released next cycle via the normal drop path.

Optional Feature:
- Macro COM_BUS_TIMEOUT_EN.
- Enabled:
  - Tenure counter clears on every processor grant and increments each cycle in PROC or PROC_SNOOP.
  - When the counter reaches TIMEOUT_CYCLES-1 with Req_proc[k] still high:
    - Gnt_proc and any Gnt_snoop drop.
    - Arb_timeout pulses high for 1 cycle.
    - Pointer = k+1 → TURN.
  - A core still requesting after a forced release is re-arbitrated normally.
- Disabled: counter and Arb_timeout port are absent; tenures are unbounded.

Test Plan:
- Reset, then Req_proc=4'b0100 held for 5 cycles, then dropped:
  - Gnt_proc=4'b0100 one cycle after the request.
  - Gnt_proc drops one cycle after the request drops.
  - Pointer=3, Proc_owner=2.
- All four Req_proc held continuously, each core dropping its request after 2 granted cycles:
  - Grant order 0,1,2,3,0.
  - One grant-free TURN cycle between each tenure.
- Core 1 holds the proc grant; Req_snoop=4'b1010 is asserted:
  - Gnt_snoop=4'b1000 (bit 1 ignored as owner), Gnt_proc stays 4'b0010.
  - Snoop grant drops one cycle after Req_snoop[3] drops.
- Req_proc=4'b0001 and Req_snoop=4'b0100 rise in the same cycle from IDLE:
  - Gnt_snoop=4'b0100 first; after release and TURN, Gnt_proc=4'b0001.
- Assert rst while in PROC_SNOOP:
  - All grants 0 and Bus_busy 0 on the next edge; pointer 0.
- With COM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, core 3 holds Req_proc for 20 cycles:
  - Forced release after 8 granted cycles, Arb_timeout high for 1 cycle.
  - If core 0 is requesting, Gnt_proc=4'b0001 after TURN.
